// File: rtl/neuron_coeff_bank_pkg.sv
// neuron_coeff_bank_pkg
//   Shared constants and helpers for the neuron coefficient bank.
//   - CTRL register bit positions (GO, CLR_OVR).
//   - Address-map helpers. The map depends on the NCoeff parameter, so it is
//     expressed as functions of ncoeff rather than as fixed constants.
//   - A small decoded-control struct with its decode function.
package neuron_coeff_bank_pkg;

  localparam int CTRL_GO_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // Address map:
  //   0..NCoeff-1 coefficients, then offset, input and CTRL/STATUS.
  function automatic int addr_offset(input int ncoeff);
    return ncoeff;
  endfunction

  function automatic int addr_input(input int ncoeff);
    return ncoeff + 1;
  endfunction

  function automatic int addr_ctrl(input int ncoeff);
    return ncoeff + 2;
  endfunction

  typedef struct packed {
    logic go;
    logic clr_ovr;
  } ctrl_cmd_t;

  function automatic ctrl_cmd_t decode_ctrl(input logic [1:0] bits);
    ctrl_cmd_t cmd;
    cmd.go      = bits[CTRL_GO_BIT];
    cmd.clr_ovr = bits[CTRL_CLR_BIT];
    return cmd;
  endfunction

endpackage

// File: rtl/neuron_coeff_bank_shadow_reg.sv
// bank_shadow_reg
//   One double-buffered register: a shadow word written by the bus and an
//   active word that takes the shadow value on commit.
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   synchronous master reset, clears shadow and active
//     clear   in   synchronous soft clear, clears shadow and active
//     wr_en   in   load wr_data into shadow
//     wr_data in   Width-bit write data
//     commit  in   copy shadow into active
//     shadow  out  current shadow word
//     active  out  current active word
//   When wr_en and commit coincide, active receives the shadow value from
//   before the edge and the new data lands in shadow only.
module bank_shadow_reg #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             commit,
  output logic [Width-1:0] shadow,
  output logic [Width-1:0] active
);

  logic [Width-1:0] shadow_reg;
  logic [Width-1:0] active_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shadow_reg <= '0;
      active_reg <= '0;
    end else begin
      if (wr_en) begin
        shadow_reg <= wr_data;
      end
      if (commit) begin
        active_reg <= shadow_reg;
      end
    end
  end

  assign shadow = shadow_reg;
  assign active = active_reg;

endmodule

// File: rtl/neuron_coeff_bank.sv
// neuron_coeff_bank
//   Double-buffered coefficient/operand bank between the write bus and a
//   neuron core. The bus writes shadow registers at any time. A GO command
//   commits all shadows to the active outputs and issues a one-cycle Start.
//   Ports:
//     CLK           in   clock, rising edge
//     Reset         in   synchronous master reset, clears everything
//     ResetStart    in   synchronous soft reset: clears input operand,
//                        Start, Busy and Overrun; coefficients and offset kept
//     Write/Read    in   bus strobes
//     Address       in   word address
//     InDatoMemoria in   bus write data
//     RdData        out  registered readback
//     RdValid       out  one-cycle readback strobe
//     Done          in   core finished current operation
//     Start         out  one-cycle pulse, active operands valid
//     Busy          out  operation in flight
//     Overrun       out  sticky, GO seen while busy
//     CoeffBus      out  active coefficients, i at [i*Width +: Width]
//     Offset        out  active offset
//     InDato        out  active input operand
module neuron_coeff_bank
  import neuron_coeff_bank_pkg::*;
#(
  parameter int Width  = 32,
  parameter int NCoeff = 20,
  parameter int AddrW  = 9
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     ResetStart,
  input  logic                     Write,
  input  logic                     Read,
  input  logic [AddrW-1:0]         Address,
  input  logic signed [Width-1:0]  InDatoMemoria,
  output logic [Width-1:0]         RdData,
  output logic                     RdValid,
  input  logic                     Done,
  output logic                     Start,
  output logic                     Busy,
  output logic                     Overrun,
  output logic [NCoeff*Width-1:0]  CoeffBus,
  output logic signed [Width-1:0]  Offset,
  output logic signed [Width-1:0]  InDato
);

  localparam int ADDR_OFFSET = addr_offset(NCoeff);
  localparam int ADDR_INPUT  = addr_input(NCoeff);
  localparam int ADDR_CTRL   = addr_ctrl(NCoeff);
  // Coefficients plus offset plus input operand.
  localparam int NREG        = NCoeff + 2;

  logic [Width-1:0] shadow [NREG];
  logic [Width-1:0] active [NREG];

  logic             start_reg;
  logic             busy_reg;
  logic             overrun_reg;
  logic [Width-1:0] rd_data_reg;
  logic             rd_valid_reg;

  logic             bus_wr;
  logic             ctrl_wr;
  ctrl_cmd_t        cmd;
  logic             go_accept;
  logic             go_reject;
  logic [Width-1:0] rd_mux;

  // The soft reset outranks bus activity, so writes are masked while it is
  // asserted (this also suppresses any GO in that cycle).
  assign bus_wr    = Write && !ResetStart;
  assign ctrl_wr   = bus_wr && (Address == AddrW'(ADDR_CTRL));
  assign cmd       = decode_ctrl(InDatoMemoria[1:0]);
  // A GO is still accepted while busy if the core finishes in the same cycle,
  // giving back-to-back operations with Busy held high.
  assign go_accept = ctrl_wr && cmd.go && (!busy_reg || Done);
  assign go_reject = ctrl_wr && cmd.go && busy_reg && !Done;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // Only the input operand is cleared by the soft reset.
      localparam bit IS_INPUT = (gi == ADDR_INPUT);

      bank_shadow_reg #(
        .Width(Width)
      ) u_reg (
        .clk    (CLK),
        .reset  (Reset),
        .clear  (ResetStart && IS_INPUT),
        .wr_en  (bus_wr && (Address == AddrW'(gi))),
        .wr_data(InDatoMemoria),
        .commit (go_accept),
        .shadow (shadow[gi]),
        .active (active[gi])
      );
    end

    for (gi = 0; gi < NCoeff; gi++) begin : g_coeff_out
      assign CoeffBus[gi*Width +: Width] = active[gi];
    end
  endgenerate

  assign Offset = active[ADDR_OFFSET];
  assign InDato = active[ADDR_INPUT];

  // Readback uses the pre-edge shadow value, so a read and a write to the
  // same address in one cycle returns the old contents.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREG; i++) begin
      if (Address == AddrW'(i)) begin
        rd_mux = shadow[i];
      end
    end
    if (Address == AddrW'(ADDR_CTRL)) begin
      rd_mux = {{(Width-2){1'b0}}, overrun_reg, busy_reg};
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else if (ResetStart) begin
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      start_reg <= go_accept;

      if (go_accept) begin
        busy_reg <= 1'b1;
      end else if (Done) begin
        busy_reg <= 1'b0;
      end

      // A rejected GO wins over a simultaneous clear.
      if (go_reject) begin
        overrun_reg <= 1'b1;
      end else if (ctrl_wr && cmd.clr_ovr) begin
        overrun_reg <= 1'b0;
      end

      rd_valid_reg <= Read;
      if (Read) begin
        rd_data_reg <= rd_mux;
      end
    end
  end

  assign Start   = start_reg;
  assign Busy    = busy_reg;
  assign Overrun = overrun_reg;
  assign RdData  = rd_data_reg;
  assign RdValid = rd_valid_reg;

endmodule

// File: tb/tb_neuron_coeff_bank.sv
module tb_neuron_coeff_bank;

  localparam int W  = 32;
  localparam int NC = 20;
  localparam int AW = 9;

  logic                CLK = 1'b0;
  logic                Reset = 1'b1;
  logic                ResetStart = 1'b0;
  logic                Write = 1'b0;
  logic                Read = 1'b0;
  logic [AW-1:0]       Address = '0;
  logic signed [W-1:0] InDatoMemoria = '0;
  logic [W-1:0]        RdData;
  logic                RdValid;
  logic                Done = 1'b0;
  logic                Start;
  logic                Busy;
  logic                Overrun;
  logic [NC*W-1:0]     CoeffBus;
  logic signed [W-1:0] Offset;
  logic signed [W-1:0] InDato;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  neuron_coeff_bank #(.Width(W), .NCoeff(NC), .AddrW(AW)) dut (
    .CLK(CLK), .Reset(Reset), .ResetStart(ResetStart),
    .Write(Write), .Read(Read), .Address(Address),
    .InDatoMemoria(InDatoMemoria), .RdData(RdData), .RdValid(RdValid),
    .Done(Done), .Start(Start), .Busy(Busy), .Overrun(Overrun),
    .CoeffBus(CoeffBus), .Offset(Offset), .InDato(InDato)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    Write = 1'b1; Address = AW'(a); InDatoMemoria = d;
    step();
    Write = 1'b0;
  endtask

  task automatic rd(input int a, input logic [W-1:0] exp);
    Read = 1'b1; Address = AW'(a);
    exp_q.push_back(exp);
    step();
    Read = 1'b0;
  endtask

  function automatic logic [W-1:0] coeff(input int i);
    return CoeffBus[i*W +: W];
  endfunction

  // Readback scoreboard: every RdValid pops the oldest expected value.
  always @(negedge CLK) begin
    if (RdValid) begin
      chk("rd_queue_nonempty", W'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("rd_data", RdData, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset
    step(); step();
    chk("rst_coeff0", coeff(0), 0);
    chk("rst_coeff19", coeff(19), 0);
    chk("rst_offset", Offset, 0);
    chk("rst_indato", InDato, 0);
    chk("rst_start", W'(Start), 0);
    chk("rst_busy", W'(Busy), 0);
    chk("rst_overrun", W'(Overrun), 0);
    chk("rst_rdvalid", W'(RdValid), 0);
    Reset = 1'b0;

    // Load + GO
    for (int i = 0; i < NC; i++) wr(i, W'(i + 1));
    wr(20, -5);
    wr(21, 7);
    chk("pre_go_coeff3", coeff(3), 0);
    wr(22, 1);
    chk("go_start", W'(Start), 1);
    chk("go_busy", W'(Busy), 1);
    chk("go_coeff3", coeff(3), 4);
    chk("go_coeff19", coeff(19), 20);
    chk("go_offset", Offset, -5);
    chk("go_indato", InDato, 7);
    step();
    chk("go_start_drop", W'(Start), 0);
    chk("go_busy_hold", W'(Busy), 1);

    // Double buffer
    wr(0, 99);
    chk("dbuf_coeff0_kept", coeff(0), 1);
    rd(0, 99);
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("done_busy", W'(Busy), 0);
    wr(22, 1);
    chk("go2_start", W'(Start), 1);
    chk("go2_coeff0", coeff(0), 99);
    step();

    // Overrun
    wr(22, 1);
    chk("ovr_no_start", W'(Start), 0);
    chk("ovr_set", W'(Overrun), 1);
    chk("ovr_busy", W'(Busy), 1);
    rd(22, 3);
    wr(22, 2);
    chk("ovr_clr", W'(Overrun), 0);
    wr(22, 3);
    chk("ovr_set_wins", W'(Overrun), 1);
    chk("ovr_set_wins_start", W'(Start), 0);

    // Read and write same address in one cycle returns old value
    Write = 1'b1; Read = 1'b1; Address = AW'(5); InDatoMemoria = 77;
    exp_q.push_back(6);
    step();
    Write = 1'b0; Read = 1'b0;
    rd(5, 77);

    // Done + GO in same cycle while busy
    Done = 1'b1; Write = 1'b1; Address = AW'(22); InDatoMemoria = 1;
    step();
    Done = 1'b0; Write = 1'b0;
    chk("dgo_start", W'(Start), 1);
    chk("dgo_busy", W'(Busy), 1);
    chk("dgo_coeff5", coeff(5), 77);
    step();
    chk("dgo_start_drop", W'(Start), 0);
    chk("dgo_busy_hold", W'(Busy), 1);

    // ResetStart mid-operation
    ResetStart = 1'b1;
    step();
    ResetStart = 1'b0;
    chk("rs_busy", W'(Busy), 0);
    chk("rs_start", W'(Start), 0);
    chk("rs_overrun", W'(Overrun), 0);
    chk("rs_indato", InDato, 0);
    chk("rs_coeff3", coeff(3), 4);
    chk("rs_offset", Offset, -5);
    wr(40, 123);
    rd(40, 0);
    rd(21, 0);
    rd(20, -5);
    rd(22, 0);
    wr(22, 1);
    chk("rego_start", W'(Start), 1);
    chk("rego_coeff0", coeff(0), 99);
    chk("rego_indato", InDato, 0);
    step(); step();
    chk("rd_pending", W'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
